// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF LCU fetch block: FSM states, parameter-word
// field positions and LCU size decode helpers.
package ipf_pkg;

    localparam int unsigned IMG_W = 128;
    localparam int unsigned PRM_W = 24;

    localparam int unsigned PRM_TYPE_LSB = 22;
    localparam int unsigned PRM_BAND_LSB = 17;
    localparam int unsigned PRM_WO_BIT   = 16;
    localparam int unsigned PRM_OFS_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARAM,
        ST_PLOAD,
        ST_STREAM,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } state_t;

    // Selector 3 is an alias of 64x64.
    function automatic logic [1:0] norm_size(input logic [1:0] sel);
        return (sel == 2'd3) ? 2'd2 : sel;
    endfunction

    function automatic logic [2:0] lcu_log2(input logic [1:0] size);
        return 3'd4 + {1'b0, size};
    endfunction

    function automatic logic [6:0] lcu_side(input logic [1:0] size);
        return 7'd16 << size;
    endfunction

    function automatic logic [3:0] lcu_count(input logic [1:0] size);
        return 4'd8 >> size;
    endfunction

endpackage

// File: rtl/ipf_lcu_fetch.sv
// Walks the 128x128 image LCU by LCU, fetches per-LCU parameters and streams
// pixels to the IPF stage, releasing rows 3..S-1 one at a time on busy.
module ipf_lcu_fetch
    import ipf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cfg_lcu_size,
    output logic             img_rd,
    output logic [13:0]      img_addr,
    input  logic [7:0]       img_data,
    output logic             prm_rd,
    output logic [5:0]       prm_addr,
    input  logic [PRM_W-1:0] prm_data,
    input  logic             busy,
    output logic             in_en,
    output logic [7:0]       din,
    output logic [1:0]       ipf_type,
    output logic [4:0]       ipf_band_pos,
    output logic             ipf_wo_class,
    output logic [15:0]      ipf_offset,
    output logic [2:0]       lcu_x,
    output logic [2:0]       lcu_y,
    output logic [1:0]       lcu_size,
    output logic             done
);

    state_t      state, state_nx;
    logic [1:0]  size_q, size_nx;
    logic [2:0]  cur_x, cur_y, x_nx, y_nx;
    logic [6:0]  row_q, row_nx;
    logic [5:0]  col_q, col_nx;
    logic        ld_prm;

    logic [6:0]  side;
    logic [2:0]  lg;
    logic [2:0]  last_idx;
    logic [6:0]  row_pix, col_pix;
    logic [5:0]  lcu_idx;

    assign side     = lcu_side(size_q);
    assign lg       = lcu_log2(size_q);
    assign last_idx = 3'(lcu_count(size_q) - 4'd1);

    always_comb begin
        state_nx = state;
        size_nx  = size_q;
        x_nx     = cur_x;
        y_nx     = cur_y;
        row_nx   = row_q;
        col_nx   = col_q;
        prm_rd   = 1'b0;
        img_rd   = 1'b0;
        ld_prm   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    size_nx  = norm_size(cfg_lcu_size);
                    x_nx     = '0;
                    y_nx     = '0;
                    state_nx = ST_PARAM;
                end
            end
            ST_PARAM: begin
                prm_rd   = 1'b1;
                state_nx = ST_PLOAD;
            end
            ST_PLOAD: begin
                ld_prm   = 1'b1;
                row_nx   = '0;
                col_nx   = '0;
                state_nx = ST_STREAM;
            end
            ST_STREAM: begin
                img_rd = 1'b1;
                if ({1'b0, col_q} == side - 7'd1) begin
                    col_nx = '0;
                    row_nx = row_q + 7'd1;
                    if (row_q >= 7'd2) begin
                        state_nx = ST_WAIT_HI;
                    end
                end else begin
                    col_nx = col_q + 6'd1;
                end
            end
            ST_WAIT_HI: begin
                if (busy) begin
                    state_nx = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!busy) begin
                    // row_q already points past the row just streamed
                    if (row_q < side) begin
                        state_nx = ST_STREAM;
                    end else if (cur_x != last_idx || cur_y != last_idx) begin
                        if (cur_x == last_idx) begin
                            x_nx = '0;
                            y_nx = cur_y + 3'd1;
                        end else begin
                            x_nx = cur_x + 3'd1;
                        end
                        state_nx = ST_PARAM;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        row_pix  = ({4'b0000, cur_y} << lg) + row_q;
        col_pix  = ({4'b0000, cur_x} << lg) + {1'b0, col_q};
        lcu_idx  = ({3'b000, cur_y} << (2'd3 - size_q)) + {3'b000, cur_x};
        img_addr = img_rd ? 14'(row_pix * IMG_W + col_pix) : '0;
        prm_addr = prm_rd ? lcu_idx : '0;
    end

    // Memory data already lags img_rd by one cycle, matching the registered in_en.
    assign din  = in_en ? img_data : '0;
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            size_q       <= '0;
            cur_x        <= '0;
            cur_y        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            in_en        <= 1'b0;
            ipf_type     <= '0;
            ipf_band_pos <= '0;
            ipf_wo_class <= 1'b0;
            ipf_offset   <= '0;
            lcu_x        <= '0;
            lcu_y        <= '0;
            lcu_size     <= '0;
        end else begin
            state  <= state_nx;
            size_q <= size_nx;
            cur_x  <= x_nx;
            cur_y  <= y_nx;
            row_q  <= row_nx;
            col_q  <= col_nx;
            in_en  <= img_rd;
            if (ld_prm) begin
                ipf_type     <= prm_data[PRM_TYPE_LSB +: 2];
                ipf_band_pos <= prm_data[PRM_BAND_LSB +: 5];
                ipf_wo_class <= prm_data[PRM_WO_BIT];
                ipf_offset   <= prm_data[PRM_OFS_LSB +: 16];
                lcu_x        <= cur_x;
                lcu_y        <= cur_y;
                lcu_size     <= size_q;
            end
        end
    end

endmodule

// File: tb/tb_ipf_lcu_fetch.sv
// Scoreboard bench for ipf_lcu_fetch: a frame-level model queues every expected
// pixel and parameter read; monitors pop and compare as the DUT produces them.
module tb_ipf_lcu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_lcu_size;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_data;
    logic        prm_rd;
    logic [5:0]  prm_addr;
    logic [23:0] prm_data;
    logic        busy;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        done;

    ipf_lcu_fetch dut (
        .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg_lcu_size),
        .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
        .prm_rd(prm_rd), .prm_addr(prm_addr), .prm_data(prm_data),
        .busy(busy), .in_en(in_en), .din(din),
        .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos),
        .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset),
        .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0]  img_mem [16384];
    logic [23:0] prm_mem [64];

    always @(posedge clk) begin
        if (img_rd) img_data <= img_mem[img_addr];
        if (prm_rd) prm_data <= prm_mem[prm_addr];
    end

    // Filter stand-in: manual level, or a free-running random toggle.
    logic        busy_man  = 1'b0;
    logic        busy_rand = 1'b0;
    logic        busy_r    = 1'b0;
    int unsigned hold      = 0;
    assign busy = busy_rand ? busy_r : busy_man;

    always @(negedge clk) begin
        if (hold != 0) hold = hold - 1;
        else begin
            busy_r = ~busy_r;
            hold   = $urandom_range(0, 2);
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned pix_cnt = 0;
    logic [39:0] exp_q[$];
    int unsigned prm_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Expected stream for one frame, straight from the raster/LCU address rule.
    task automatic push_frame(input logic [1:0] cfg);
        int unsigned sz, s, n, idx;
        logic [23:0] w;
        logic [7:0]  pix;
        sz = (cfg == 2'd3) ? 2 : int'(cfg);
        s  = 16 << sz;
        n  = 8 >> sz;
        for (int unsigned ly = 0; ly < n; ly++) begin
            for (int unsigned lx = 0; lx < n; lx++) begin
                idx = ly * n + lx;
                prm_q.push_back(idx);
                w = prm_mem[idx];
                for (int unsigned r = 0; r < s; r++) begin
                    for (int unsigned c = 0; c < s; c++) begin
                        pix = img_mem[14'((ly * s + r) * 128 + lx * s + c)];
                        exp_q.push_back({pix, 3'(lx), 3'(ly), 2'(sz), w});
                    end
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (prm_rd) begin
                if (prm_q.size() == 0) fail_now("prm_read", "unexpected parameter read");
                else chk("prm_addr", 64'(prm_addr), 64'(prm_q.pop_front()));
            end
            if (in_en) begin
                logic [39:0] e;
                pix_cnt++;
                if (exp_q.size() == 0) fail_now("pixel", "pixel delivered with none expected");
                else begin
                    e = exp_q.pop_front();
                    chk("pixel", 64'({din, lcu_x, lcu_y, lcu_size, ipf_type, ipf_band_pos,
                                      ipf_wo_class, ipf_offset}), 64'(e));
                    if (e[23:0] == 24'hA5F3C1)
                        chk("lcu1_fields", 64'({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}),
                            64'({2'd2, 5'd18, 1'b1, 16'hF3C1}));
                end
            end
        end
    end

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outputs();
        return {img_rd, img_addr, prm_rd, prm_addr, in_en, din, ipf_type, ipf_band_pos,
                ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size, done};
    endfunction

    task automatic do_reset(input string name);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk(name, all_outputs(), 64'd0);
        exp_q.delete();
        prm_q.delete();
        pix_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] sz);
        @(negedge clk);
        cfg_lcu_size = sz;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_in_en_low(input string name);
        int unsigned i;
        i = 0;
        do begin
            sample();
            i++;
        end while (in_en && i < 200);
        if (in_en) fail_now(name, "row end not reached within 200 cycles");
    endtask

    task automatic resume_check(input string name);
        logic a, b;
        @(negedge clk);
        busy_man = 1'b0;
        sample(); a = in_en;
        sample(); b = in_en;
        chk(name, 64'({a, b}), 64'(2'b01));
    endtask

    task automatic wait_done(input string name);
        int unsigned i;
        i = 0;
        while (!done && i < 40000) begin
            sample();
            i++;
        end
        if (!done) fail_now(name, "done not raised within 40000 cycles");
        else begin
            chk({name, "_drained"}, 64'(exp_q.size() + prm_q.size()), 64'd0);
            repeat (10) sample();
            chk({name, "_done_held"}, 64'(done), 64'd1);
        end
    endtask

    initial begin
        logic [3:0]  lat;
        logic        rd3, prm1;
        int unsigned cnt, ones, i;

        reset = 1'b1;
        start = 1'b0;
        cfg_lcu_size = 2'd0;
        for (int a = 0; a < 16384; a++) img_mem[a] = 8'(a);
        for (int a = 0; a < 64; a++) prm_mem[a] = 24'($urandom);
        prm_mem[1] = 24'hA5F3C1;

        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outputs(), 64'd0);
        reset = 1'b0;
        ones = 0;
        repeat (4) begin
            sample();
            if (all_outputs() != 64'd0) ones++;
        end
        chk("idle_after_reset", 64'(ones), 64'd0);

        // Size 16, first LCU: latency, 3-row burst, stall and row release.
        push_frame(2'd0);
        @(negedge clk);
        cfg_lcu_size = 2'd0;
        start = 1'b1;
        sample();
        lat[0] = in_en;
        prm1   = prm_rd;
        @(negedge clk);
        start = 1'b0;
        sample(); lat[1] = in_en;
        sample(); lat[2] = in_en; rd3 = img_rd;
        sample(); lat[3] = in_en;
        chk("start_latency", 64'(lat), 64'(4'b1000));
        chk("first_rd_timing", 64'({prm1, rd3}), 64'(2'b11));
        cnt = 1;
        for (i = 0; i < 200; i++) begin
            sample();
            if (!in_en) break;
            cnt++;
        end
        chk("burst_len", 64'(cnt), 64'd48);
        ones = 0;
        repeat (5) begin
            sample();
            if (in_en) ones++;
        end
        chk("stall_no_pixel", 64'(ones), 64'd0);
        @(negedge clk);
        busy_man = 1'b1;
        repeat (4) @(negedge clk);
        resume_check("resume_latency");

        // Busy already high when row 3 ends: WAIT_HI must leave after one cycle.
        @(negedge clk);
        busy_man = 1'b1;
        wait_in_en_low("row3_end");
        resume_check("busy_prehigh_resume");

        // Row 4 end with busy held high: no resume until it falls.
        @(negedge clk);
        busy_man = 1'b1;
        wait_in_en_low("row4_end");
        ones = 0;
        repeat (6) begin
            sample();
            if (in_en || img_rd) ones++;
        end
        chk("hold_while_busy", 64'(ones), 64'd0);
        resume_check("busy_fall_resume");
        do_reset("reset_abort_a");

        // Size 32 with random data and busy; reset in LCU 2 row 5.
        for (int a = 0; a < 16384; a++) img_mem[a] = 8'($urandom);
        busy_rand = 1'b1;
        push_frame(2'd1);
        pulse_start(2'd1);
        i = 0;
        while (pix_cnt < 2 * 1024 + 5 * 32 + 3 && i < 20000) begin
            sample();
            i++;
        end
        if (pix_cnt < 2 * 1024 + 5 * 32 + 3) fail_now("reach_lcu2", "LCU 2 row 5 not reached");
        do_reset("reset_mid_frame");
        ones = 0;
        repeat (8) begin
            sample();
            if (in_en || img_rd || prm_rd || done) ones++;
        end
        chk("idle_after_abort", 64'(ones), 64'd0);

        // Full size-32 frame from scratch; a stray start mid-stream must be ignored.
        push_frame(2'd1);
        pulse_start(2'd1);
        i = 0;
        while (!(pix_cnt >= 700 && in_en) && i < 20000) begin
            sample();
            i++;
        end
        if (!in_en) fail_now("stream_reach", "streaming not observed");
        pulse_start(2'd0);
        wait_done("frame_s32");

        // Size 64 frame started from DONE.
        push_frame(2'd2);
        pulse_start(2'd2);
        sample();
        chk("done_cleared_s64", 64'(done), 64'd0);
        wait_done("frame_s64");

        // Selector 3 must behave as size 64.
        push_frame(2'd3);
        pulse_start(2'd3);
        sample();
        chk("done_cleared_sel3", 64'(done), 64'd0);
        wait_done("frame_sel3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
